// File: rtl/sar_adc_ctrl_if.sv
// Bus between the SAR controller and its comparator/DAC front end.
// SAR_ADC_ABORT_EN adds the abort request line.
interface sar_adc_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             cmp;
  logic [WIDTH-1:0] dac_code;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
`ifdef SAR_ADC_ABORT_EN
  logic             abort;

  modport master (output start, cmp, abort, input dac_code, busy, done, result);
  modport slave  (input start, cmp, abort, output dac_code, busy, done, result);
`else
  modport master (output start, cmp, input dac_code, busy, done, result);
  modport slave  (input start, cmp, output dac_code, busy, done, result);
`endif
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: MSB-first binary search with per-bit DAC settling.
// Optional feature macro: SAR_ADC_ABORT_EN (adds an abort request that cancels a conversion).
module sar_adc_ctrl #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2
) (
  input logic           clk,
  input logic           rst_n,
  sar_adc_ctrl_if.slave bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MSB_ONLY   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0] TOP_IDX    = IDX_W'(WIDTH - 1);
  localparam logic [3:0]       SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, WAIT, DECIDE, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dac_code;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic [3:0]       cnt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] decide_code;
  logic             abort_req;

`ifdef SAR_ADC_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // Code after resolving the current bit and, if any remain, trialling the next lower bit.
  always_comb begin
    decide_code = dac_code;
    if (!bus.cmp) begin
      decide_code[idx] = 1'b0;
    end
    if (idx != '0) begin
      decide_code[idx - 1'b1] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      dac_code <= '0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      idx      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dac_code <= MSB_ONLY;
            idx      <= TOP_IDX;
            cnt      <= SETTLE_CNT;
            busy     <= 1'b1;
            state    <= (SETTLE == 0) ? DECIDE : WAIT;
          end
        end
        WAIT: begin
          if (abort_req) begin
            state    <= IDLE;
            busy     <= 1'b0;
            dac_code <= '0;
            cnt      <= '0;
            idx      <= '0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt <= 4'd1) begin
              state <= DECIDE;
            end
          end
        end
        DECIDE: begin
          if (abort_req) begin
            state    <= IDLE;
            busy     <= 1'b0;
            dac_code <= '0;
            cnt      <= '0;
            idx      <= '0;
          end else begin
            dac_code <= decide_code;
            if (idx == '0) begin
              // done and result are registered on entry so they are valid during DONE.
              state  <= DONE;
              done   <= 1'b1;
              result <= decide_code;
            end else begin
              idx   <= idx - 1'b1;
              cnt   <= SETTLE_CNT;
              state <= (SETTLE == 0) ? DECIDE : WAIT;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dac_code = dac_code;
  assign bus.result   = result;
  assign bus.busy     = busy;
  assign bus.done     = done;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl: an 8-bit/settle-2 and a 4-bit/settle-0 instance
// checked against a binary-search reference model; abort tests need SAR_ADC_ABORT_EN.
module tb_sar_adc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_drv;
  logic        abort_drv;
  logic        sel;
  logic [15:0] vin;
  int          tests_run;
  int          tests_failed;
  int          cur_w;
  int          cur_s;

  logic        obs_busy;
  logic        obs_done;
  logic [15:0] obs_dac;
  logic [15:0] obs_result;

  always #5 clk = ~clk;

  sar_adc_ctrl_if #(.WIDTH(8)) bus_a ();
  sar_adc_ctrl_if #(.WIDTH(4)) bus_b ();

  assign bus_a.start = start_drv & ~sel;
  assign bus_b.start = start_drv & sel;
  assign bus_a.cmp   = (vin >= 16'(bus_a.dac_code));
  assign bus_b.cmp   = (vin >= 16'(bus_b.dac_code));
`ifdef SAR_ADC_ABORT_EN
  assign bus_a.abort = abort_drv & ~sel;
  assign bus_b.abort = abort_drv & sel;
`endif

  sar_adc_ctrl #(.WIDTH(8), .SETTLE(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  sar_adc_ctrl #(.WIDTH(4), .SETTLE(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  always_comb begin
    obs_busy   = sel ? bus_b.busy : bus_a.busy;
    obs_done   = sel ? bus_b.done : bus_a.done;
    obs_dac    = sel ? 16'(bus_b.dac_code) : 16'(bus_a.dac_code);
    obs_result = sel ? 16'(bus_b.result) : 16'(bus_a.result);
  end

  // Reference: the code presented to the DAC while resolving the j-th bit counted from the MSB.
  function automatic logic [15:0] trial_code(input int w, input logic [15:0] v, input int j);
    logic [15:0] acc;
    logic [15:0] t;
    acc = '0;
    t   = '0;
    for (int i = 0; i <= j; i++) begin
      t = acc | (16'd1 << (w - 1 - i));
      if (i < j && v >= t) acc = t;
    end
    return t;
  endfunction

  function automatic logic [15:0] sar_search(input int w, input logic [15:0] v);
    logic [15:0] acc;
    logic [15:0] t;
    acc = '0;
    for (int i = 0; i < w; i++) begin
      t = acc | (16'd1 << (w - 1 - i));
      if (v >= t) acc = t;
    end
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic select_dut(input logic b);
    sel   = b;
    cur_w = b ? 4 : 8;
    cur_s = b ? 0 : 2;
    #1;
  endtask

  // Observation k is taken just after edge k, edge 0 being the one that samples start.
  task automatic run_conversion(input logic [15:0] v, input int restart_at, input int abort_at);
    int          lat;
    logic [15:0] exp_dac;
    logic [15:0] final_code;
    lat        = cur_w * (cur_s + 1);
    final_code = sar_search(cur_w, v);
    vin        = v;
    start_drv  = 1'b1;
    tick();
    start_drv  = 1'b0;
    for (int k = 0; k <= lat; k++) begin
      exp_dac = (k < lat) ? trial_code(cur_w, v, k / (cur_s + 1)) : final_code;
      tests_run++;
      if (obs_busy !== 1'b1 || obs_done !== (k == lat) || obs_dac !== exp_dac) begin
        tests_failed++;
        $display("[TB] FAIL conv v=%h k=%0d: busy=%b done=%b dac=%h, required busy=1 done=%b dac=%h",
                 v, k, obs_busy, obs_done, obs_dac, (k == lat), exp_dac);
      end
      if (k == lat) begin
        tests_run++;
        if (obs_result !== final_code) begin
          tests_failed++;
          $display("[TB] FAIL result v=%h: got %h, required %h", v, obs_result, final_code);
        end
      end
      start_drv = (k == restart_at);
      abort_drv = (k == abort_at);
      tick();
    end
    start_drv = 1'b0;
    abort_drv = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_dac !== final_code || obs_result !== final_code) begin
        tests_failed++;
        $display("[TB] FAIL idle after v=%h: busy=%b done=%b dac=%h result=%h, required 0 0 %h %h",
                 v, obs_busy, obs_done, obs_dac, obs_result, final_code, final_code);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    start_drv = 1'b1;
    abort_drv = 1'b0;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      select_dut(d[0]);
      tests_run++;
      if (obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_dac !== 16'h0 || obs_result !== 16'h0) begin
        tests_failed++;
        $display("[TB] FAIL reset dut%0d: busy=%b done=%b dac=%h result=%h, required all 0",
                 d, obs_busy, obs_done, obs_dac, obs_result);
      end
    end
    start_drv = 1'b0;
    rst_n     = 1'b1;
    tick();
  endtask

  task automatic test_boundaries();
    select_dut(1'b0);
    run_conversion(16'hA5, -1, -1);
    run_conversion(16'h00, -1, -1);
    run_conversion(16'hFF, -1, -1);
    select_dut(1'b1);
    run_conversion(16'h0, -1, -1);
    run_conversion(16'hF, -1, -1);
  endtask

  task automatic test_random_conversions();
    select_dut(1'b0);
    for (int n = 0; n < 6; n++) run_conversion(16'($urandom_range(0, 255)), -1, -1);
    select_dut(1'b1);
    for (int n = 0; n < 4; n++) run_conversion(16'($urandom_range(0, 15)), -1, -1);
  endtask

  task automatic test_start_while_busy();
    select_dut(1'b0);
    run_conversion(16'hA5, 9, -1);
    run_conversion(16'($urandom_range(0, 255)), 17, -1);
  endtask

  task automatic test_mid_reset();
    select_dut(1'b0);
    vin       = 16'h5A;
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    for (int k = 0; k < 11; k++) tick();
    rst_n = 1'b0;
    tick();
    tests_run++;
    if (obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_dac !== 16'h0 || obs_result !== 16'h0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: busy=%b done=%b dac=%h result=%h, required all 0",
               obs_busy, obs_done, obs_dac, obs_result);
    end
    rst_n = 1'b1;
    tick();
    run_conversion(16'h5A, -1, -1);
  endtask

  task automatic test_back_to_back();
    select_dut(1'b1);
    vin       = 16'h9;
    start_drv = 1'b1;
    tick();
    for (int k = 0; k < 18; k++) begin
      tests_run++;
      if (obs_done !== (k % 6 == 4) || (obs_done === 1'b1 && obs_result !== 16'h9)) begin
        tests_failed++;
        $display("[TB] FAIL back_to_back k=%0d: done=%b result=%h, required done=%b result=9",
                 k, obs_done, obs_result, (k % 6 == 4));
      end
      if (k == 17) start_drv = 1'b0;
      tick();
    end
    tests_run++;
    if (obs_busy !== 1'b0 || obs_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back stop: busy=%b done=%b, required 0 0", obs_busy, obs_done);
    end
    tick();
  endtask

`ifdef SAR_ADC_ABORT_EN
  task automatic abort_at_obs(input int at, input logic [15:0] keep);
    vin       = 16'($urandom_range(0, 255));
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    for (int k = 0; k < at; k++) tick();
    abort_drv = 1'b1;
    tick();
    abort_drv = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_dac !== 16'h0 || obs_result !== keep) begin
        tests_failed++;
        $display("[TB] FAIL abort at=%0d: busy=%b done=%b dac=%h result=%h, required 0 0 0 %h",
                 at, obs_busy, obs_done, obs_dac, obs_result, keep);
      end
      tick();
    end
  endtask

  task automatic test_abort();
    select_dut(1'b0);
    run_conversion(16'h33, -1, -1);
    abort_at_obs(6, 16'h33);
    abort_at_obs(5, 16'h33);
    abort_drv = 1'b1;
    tick();
    abort_drv = 1'b0;
    tests_run++;
    if (obs_busy !== 1'b0 || obs_dac !== 16'h0 || obs_result !== 16'h33) begin
      tests_failed++;
      $display("[TB] FAIL abort_idle: busy=%b dac=%h result=%h, required 0 0 33",
               obs_busy, obs_dac, obs_result);
    end
    run_conversion(16'hC4, -1, 24);
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    sel          = 1'b0;
    vin          = '0;
    start_drv    = 1'b0;
    abort_drv    = 1'b0;
    rst_n        = 1'b0;
    cur_w        = 8;
    cur_s        = 2;
    test_reset();
    test_boundaries();
    test_random_conversions();
    test_start_while_busy();
    test_mid_reset();
    test_back_to_back();
`ifdef SAR_ADC_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sar_adc_ctrl.md
SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, the conversion resolution in bits (2..16).
REQ-002 SHALL provide parameter SETTLE, default 2, the DAC settling wait in clock cycles per bit (0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  conversion request; sampled only in IDLE.
REQ-006 SHALL have port cmp  input  1  comparator output; 1 when the analog input is at or above the DAC output.
REQ-007 SHALL have port dac_code  output  WIDTH  trial code that drives the DAC.
REQ-008 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when a conversion completes.
REQ-010 SHALL have port result  output  WIDTH  last completed conversion; held until the next completion.

Function
REQ-011 SHALL implement states IDLE, WAIT, DECIDE and DONE, with a bit index running from WIDTH-1 down to 0.
REQ-012 In IDLE with start=1, SHALL load dac_code with only the MSB set, set the bit index to WIDTH-1, load the wait counter with SETTLE, and enter WAIT (or DECIDE if SETTLE=0).
REQ-013 In WAIT, SHALL decrement the counter each cycle and enter DECIDE on the cycle the counter reaches 0; dac_code is stable throughout.
REQ-014 In DECIDE, SHALL sample cmp: cmp=0 clears the current bit, cmp=1 keeps it.
REQ-015 In DECIDE, if the index is above 0, SHALL also set the next lower bit, decrement the index, reload the counter, and return to WAIT (or DECIDE if SETTLE=0).
REQ-016 In DECIDE, if the index is 0, SHALL enter DONE.
REQ-017 In DONE, SHALL copy the final dac_code into result, assert done for exactly that one cycle, then return to IDLE.
REQ-018 Latency: done SHALL be high in cycle WIDTH*(SETTLE+1)+1, counting the edge that samples start as cycle 0 (WIDTH=8, SETTLE=2 gives cycle 25).
REQ-019 busy SHALL be high in WAIT, DECIDE and DONE, and low in IDLE.
REQ-020 start while busy=1 SHALL be ignored and neither queued nor restarting the conversion.
REQ-021 start held high continuously SHALL begin a new conversion on the first IDLE cycle after DONE (back-to-back conversions).
REQ-022 cmp SHALL be ignored in every state except DECIDE.
REQ-023 dac_code SHALL stay at its final value in IDLE until the next start.

Reset
REQ-024 With rst_n=0 at a rising edge, SHALL enter IDLE with dac_code=0, result=0, busy=0, done=0 and the counter and index cleared.
REQ-025 Reset mid-conversion SHALL abandon the conversion without a done pulse; result returns to 0.
REQ-026 Reset SHALL take priority over start and over SAR_ADC_ABORT_EN abort.

Configuration
REQ-027 Macro SAR_ADC_ABORT_EN defined SHALL add input port abort (1 bit).
REQ-028 With SAR_ADC_ABORT_EN defined, abort=1 in WAIT or DECIDE SHALL return to IDLE on the next edge: no done pulse, result unchanged, dac_code cleared to 0.
REQ-029 With SAR_ADC_ABORT_EN defined, abort=1 in IDLE or DONE SHALL have no effect, and abort SHALL take priority over cmp in DECIDE.
REQ-030 Macro SAR_ADC_ABORT_EN undefined SHALL leave no abort port, and conversions SHALL always run to completion or reset.

Verification
REQ-031 WIDTH=8, SETTLE=2, cmp=(0xA5>=dac_code), pulse start -> done in cycle 25, result=0xA5, busy high cycles 1..25.
REQ-032 Same setup with vin 0x00 and then 0xFF -> result=0x00 and result=0xFF respectively; dac_code trial sequence for 0x00 is 0x80,0x40,...,0x01.
REQ-033 start pulsed again at cycle 10 of a conversion -> no restart, done still at cycle 25, exactly one done pulse.
REQ-034 rst_n=0 at cycle 12, vin=0x5A -> next cycle busy=0, dac_code=0, result=0, no done; a following start converts 0x5A correctly.
REQ-035 SETTLE=0, WIDTH=4, vin=0x9, start held high -> done every 6 cycles (first at cycle 5), result=0x9 each time.
REQ-036 SAR_ADC_ABORT_EN defined: after a completed 0x33, abort at cycle 7 of the next conversion -> IDLE next cycle, no done, result stays 0x33.
